// File: rtl/rr_arbiter8_if.sv
// Handshake bundle between the requesters and the round-robin arbiter that
// steers the shared 8-to-1 mux select.
interface rr_arbiter8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] select;
   logic       busy;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  grant,
      input  select,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant,
      output select,
      output busy,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-cycle limit; one grant at a time,
// registered one-hot grant plus binary select for the shared mux.
module rr_arbiter8 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   rr_arbiter8_if.slave bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

   // First set request bit scanning upward from ptr with wrap-around.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] idx;
      logic [2:0] res;
      logic       found;
      res   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            res   = idx;
         end else begin
            found = found;
         end
      end
      return res;
   endfunction

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] select_q, select_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;
   logic [2:0] pick_s;

   // Next-state and next-output logic for the IDLE/GRANT controller.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      select_d  = select_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      pick_s    = rr_pick(bus.req, ptr_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.req != 8'h00) begin
               state_d  = ST_GRANT;
               grant_d  = onehot8(pick_s);
               select_d = pick_s;
               busy_d   = 1'b1;
               ptr_d    = pick_s + 3'd1;
               cnt_d    = 8'd0;
            end else begin
               grant_d = 8'h00;
               busy_d  = 1'b0;
            end
         end
         ST_GRANT: begin
            // Normal release outranks the hold limit, so done suppresses timeout.
            if (bus.done || !bus.req[select_q]) begin
               state_d = ST_IDLE;
               grant_d = 8'h00;
               busy_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               grant_d   = 8'h00;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 8'h00;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         cnt_q     <= 8'd0;
         grant_q   <= 8'h00;
         select_q  <= 3'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         select_q  <= select_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.select  = select_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one 8-input datapath resource among eight requesters by sequencing the 3-bit `select` of the team's 8-to-1 multiplexer. It grants one requester at a time, holds the grant until that requester signals completion or drops its request, and bounds each tenure with a hold-cycle limit. It sits between requester-side control logic (register-file ports, memory clients, bus masters in the multi-cycle CPU) and the mux instance it steers.

## Interface
- `HOLD_MAX`, 16: maximum cycles a grant may be held before forced release; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit i = requester i wants the resource.
- `done`  in  1  granted requester finished its transfer this cycle; ignored when no grant is active.
- `grant`  out  8  one-hot grant, registered; all-zero when idle.
- `select`  out  3  binary index of the granted requester, wired to the mux select; registered.
- `busy`  out  1  high while a grant is active (equals `|grant`).
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released by the hold limit.

## Operation
- Internal state: FSM {IDLE, GRANT}, 3-bit priority pointer `ptr`, 8-bit hold counter `cnt`.
- Reset: state IDLE, `grant`=0, `select`=0, `busy`=0, `timeout`=0, `ptr`=0, `cnt`=0. Reset asserted mid-grant aborts the tenure immediately with no `timeout` pulse.
- IDLE: if `req`≠0, pick the first set bit scanning `ptr`, `ptr`+1, …, 7, 0, …, `ptr`−1 (mod 8). Register grant/select for that index k, set `ptr`←(k+1) mod 8 (7 wraps to 0), `cnt`←0, go to GRANT. If `req`=0, stay IDLE; `select` holds its last value.
- GRANT (index k), evaluated in priority order each cycle:
  1. `done`=1 or `req[k]`=0 → release: next state IDLE, `grant`←0.
  2. else `cnt`=HOLD_MAX−1 → forced release: IDLE, `grant`←0, `timeout`←1 for one cycle.
  3. else `cnt`←`cnt`+1, grant held.
- `done` and the hold limit in the same cycle: normal release wins, no `timeout`.
- Requests from other indices during GRANT are never preemptive; they are only considered in the next IDLE cycle.
- `select` changes only when a new grant is issued; never glitches during a tenure.
- Exactly one `grant` bit or none; `select` always equals the index of the set bit while `busy`=1.

## Timing
- Arbitration latency: `req` sampled in IDLE cycle N → `grant`/`select`/`busy` valid from cycle N+1.
- Release latency: `done` (or drop of `req[k]`) sampled in cycle M → `grant`=0 in cycle M+1; earliest next grant in M+2 (one mandatory idle cycle between tenures).
- Tenure length: at most HOLD_MAX cycles with `grant` high; forced release drops `grant` and raises `timeout` in the same cycle, after HOLD_MAX grant cycles.
- `timeout` is low in every other cycle, including the cycle after it pulses.
- All outputs are registered; no combinational path from `req`/`done` to any output.

## Test plan
- Reset: hold `rst` 2 cycles with `req`=8'hFF → all outputs 0; release `rst` → `grant`=8'h01, `select`=0 in the first cycle after arbitration.
- Round-robin fairness: `req`=8'hFF constant, `done` pulsed one cycle after each grant → grant sequence 0,1,2,…,7,0 with one idle cycle between each; `select` tracks.
- Pointer wrap and skip: grant index 6 completes, `req`=8'h41 → next grant is index 0 (`grant`=8'h01), then index 6.
- Hold limit: HOLD_MAX=4, `req`=8'h08 constant, `done`=0 → `grant`=8'h08 for exactly 4 cycles, then `grant`=0 with `timeout`=1 for one cycle, then re-grant to 3 next cycle.
- Simultaneous events: assert `done` on the cycle `cnt`=HOLD_MAX−1 → release with `timeout`=0; drop `req[k]` mid-tenure → release next cycle, no `timeout`.
- Reset mid-grant: `rst` during an active grant of index 5 → next cycle all outputs 0, `ptr`=0; with `req`=8'h21 afterward, index 0 is granted first.
